// File: rtl/fast_control_gen_pkg.sv
// Shared fast-control definitions: command bit positions within each 4-bit nibble
// and the aux-port width helper used by the generator top.
package fast_control_gen_pkg;

    localparam int FC_BCR          = 0;
    localparam int FC_L1A          = 1;
    localparam int FC_LINK_RESET   = 2;
    localparam int FC_BUFFER_CLEAR = 3;

    typedef logic [3:0] fc_cmd_t;

    // A one-nibble stream has no aux bits; keep a 1-bit stub so the port stays legal.
    function automatic int aux_width(input int num_nib);
        return (num_nib > 1) ? (4 * num_nib - 4) : 1;
    endfunction

endpackage

// File: rtl/fast_control_gen_hamming84_enc.sv
// Hamming(8,4) encoder: positions 1..7 follow the classic (7,4) layout, bit 0 is
// overall even parity so the decoder can tell single from double errors.
module hamming84_enc (
    input  logic [3:0] data_i,
    output logic [7:0] code_o
);

    logic p1;
    logic p2;
    logic p4;
    logic [7:1] code_hi;

    assign p1      = data_i[0] ^ data_i[1] ^ data_i[3];
    assign p2      = data_i[0] ^ data_i[2] ^ data_i[3];
    assign p4      = data_i[1] ^ data_i[2] ^ data_i[3];
    assign code_hi = {data_i[3], data_i[2], data_i[1], p4, data_i[0], p2, p1};
    assign code_o  = {code_hi, ^code_hi};

endmodule

// File: rtl/fast_control_gen.sv
// Fast-control command generator: BX/orbit counter, BCR, periodic and requested L1A
// with deadtime, pending link-reset/buffer-clear, Hamming-encoded output stream.
module fast_control_gen
    import fast_control_gen_pkg::*;
#(
    parameter int BX_W    = 12,
    parameter int NUM_NIB = 2,
    parameter int PER_W   = 16,
    parameter int DT_W    = 8
) (
    input  logic                          clk_bx,
    input  logic                          reset_n,
    input  logic [BX_W-1:0]               orb_length,
    input  logic [BX_W-1:0]               bcr_offset,
    input  logic [PER_W-1:0]              l1a_period,
    input  logic [DT_W-1:0]               l1a_deadtime,
    input  logic                          req_l1a,
    input  logic                          req_link_reset,
    input  logic                          req_buffer_clear,
    input  logic [aux_width(NUM_NIB)-1:0] aux_bits,
    output logic [8*NUM_NIB-1:0]          fc_stream_enc,
    output logic [BX_W-1:0]               bx_count,
    output logic [31:0]                   l1a_count,
    output logic [15:0]                   l1a_dropped
);

    logic [BX_W-1:0]      bx_q, bx_d;
    logic [BX_W:0]        bx_inc;
    logic [PER_W-1:0]     per_q, per_d;
    logic [DT_W-1:0]      dt_q, dt_d;
    logic                 cand_q, bcr_q, lr_pend_q, bc_pend_q;
    logic                 per_tc, bcr_hit, issue, drop;
    logic [4*NUM_NIB-1:0] aux_word, word_q, word_d;
    logic [8*NUM_NIB-1:0] enc_q, enc_d;
    logic [31:0]          l1a_cnt_q;
    logic [15:0]          drop_q;
    fc_cmd_t              cmd;

    if (NUM_NIB > 1) begin : g_aux
        assign aux_word = {aux_bits, 4'h0};
    end else begin : g_no_aux
        assign aux_word = '0;
    end

    always_comb begin
        bx_inc = {1'b0, bx_q} + (BX_W+1)'(1);
        bx_d   = bx_inc[BX_W-1:0];
        if (orb_length <= BX_W'(1) || bx_inc >= {1'b0, orb_length}) begin
            bx_d = '0;
        end

        // >= rather than == so a period shrunk below the current count recovers at once
        per_tc = (l1a_period != '0) && (per_q >= l1a_period - PER_W'(1));
        per_d  = (per_tc || l1a_period == '0) ? '0 : per_q + PER_W'(1);

        bcr_hit = (bcr_offset < orb_length) && (bx_q == bcr_offset);
        issue   = cand_q && (dt_q == '0);
        drop    = cand_q && (dt_q != '0);
        dt_d    = issue ? l1a_deadtime : ((dt_q != '0) ? dt_q - DT_W'(1) : '0);

        cmd                  = '0;
        cmd[FC_BCR]          = bcr_q;
        cmd[FC_L1A]          = issue;
        cmd[FC_LINK_RESET]   = lr_pend_q & ~bcr_q;
        cmd[FC_BUFFER_CLEAR] = bc_pend_q & ~bcr_q;
        word_d               = aux_word;
        word_d[3:0]          = cmd;
    end

    for (genvar k = 0; k < NUM_NIB; k++) begin : g_enc
        hamming84_enc u_enc (
            .data_i (word_q[4*k +: 4]),
            .code_o (enc_d[8*k +: 8])
        );
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            bx_q      <= '0;
            per_q     <= '0;
            dt_q      <= '0;
            cand_q    <= 1'b0;
            bcr_q     <= 1'b0;
            lr_pend_q <= 1'b0;
            bc_pend_q <= 1'b0;
            word_q    <= '0;
            enc_q     <= '0;
            l1a_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            bx_q      <= bx_d;
            per_q     <= per_d;
            dt_q      <= dt_d;
            cand_q    <= req_l1a | per_tc;
            bcr_q     <= bcr_hit;
            // a flag held back by a BCR word stays armed; a fresh request always re-arms
            lr_pend_q <= req_link_reset   | (lr_pend_q & bcr_q);
            bc_pend_q <= req_buffer_clear | (bc_pend_q & bcr_q);
            word_q    <= word_d;
            enc_q     <= enc_d;
            l1a_cnt_q <= l1a_cnt_q + 32'(issue);
            if (drop && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign fc_stream_enc = enc_q;
    assign bx_count      = bx_q;
    assign l1a_count     = l1a_cnt_q;
    assign l1a_dropped   = drop_q;

endmodule
